// File: rtl/aclint_multi.sv
// Multi-hart ACLINT slave: per-hart MSIP bits, a shared prescaled 64-bit MTIME
// and per-hart MTIMECMP registers driving MTIP, all behind one Membus port.
module aclint_multi #(
  parameter int unsigned     NUM_HARTS = 2,
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] BASE_ADDR = XLEN'('h0200_0000),
  parameter int unsigned     MTIME_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_membus_valid,
  output logic                 o_membus_ready,
  input  logic [XLEN-1:0]      i_membus_addr,
  input  logic                 i_membus_wen,
  input  logic [63:0]          i_membus_wdata,
  input  logic [7:0]           i_membus_wmask,
  output logic                 o_membus_rvalid,
  output logic [63:0]          o_membus_rdata,
  output logic [NUM_HARTS-1:0] o_msip,
  output logic [NUM_HARTS-1:0] o_mtip,
  output logic [63:0]          o_mtime
);

  localparam int unsigned     DIV_W     = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
  localparam logic [XLEN-1:0] OFF_CMP   = XLEN'('h4000);
  localparam logic [XLEN-1:0] OFF_MTIME = XLEN'('hBFF8);

  function automatic logic [63:0] wmask_expand(input logic [7:0] mask);
    logic [63:0] bits;
    for (int i = 0; i < 8; i++) bits[8*i +: 8] = {8{mask[i]}};
    return bits;
  endfunction

  logic [XLEN-1:0]      w_off;
  logic [XLEN-1:0]      w_msip_lo;
  logic [XLEN-1:0]      w_cmp_idx;
  logic [63:0]          w_mask;
  logic [63:0]          w_rd_data;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_is_msip;
  logic                 w_is_cmp;
  logic                 w_is_mtime;
  logic                 w_tick;

  logic [NUM_HARTS-1:0] r_msip;
  logic [63:0]          r_mtimecmp [NUM_HARTS];
  logic [63:0]          r_mtime;
  logic [DIV_W-1:0]     r_div;
  logic                 r_rvalid;
  logic [63:0]          r_rdata;

  assign w_off      = (i_membus_addr - BASE_ADDR) & ~XLEN'(7);
  assign w_wr       = i_membus_valid & i_membus_wen;
  assign w_rd       = i_membus_valid & ~i_membus_wen;
  assign w_is_msip  = w_off < OFF_CMP;
  assign w_is_cmp   = (w_off >= OFF_CMP) && (w_off < OFF_MTIME);
  assign w_is_mtime = w_off == OFF_MTIME;
  // Doubleword k of the MSIP region covers harts 2k and 2k+1, so hart = off/4.
  assign w_msip_lo  = w_off >> 2;
  assign w_cmp_idx  = (w_off - OFF_CMP) >> 3;
  assign w_mask     = wmask_expand(i_membus_wmask);
  assign w_tick     = r_div == DIV_W'(MTIME_DIV - 1);

  always_comb begin
    // NOTE: every combinational output gets a default first so a decode miss cannot infer a latch.
    w_rd_data = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (w_is_msip && (XLEN'(h) == w_msip_lo))        w_rd_data[0]  = r_msip[h];
      if (w_is_msip && (XLEN'(h) == w_msip_lo + 1'b1)) w_rd_data[32] = r_msip[h];
      if (w_is_cmp  && (XLEN'(h) == w_cmp_idx))        w_rd_data     = r_mtimecmp[h];
    end
    if (w_is_mtime) w_rd_data = r_mtime;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_msip <= '0;
      // NOTE: the compare array is architectural state that must power up all-ones so no
      // MTIP fires out of reset; it is reset explicitly like any other register.
      for (int h = 0; h < NUM_HARTS; h++) r_mtimecmp[h] <= '1;
    end else if (w_wr) begin
      // NOTE: non-blocking updates mean every register samples pre-edge values, which is
      // what lets a read in the same cycle see the old state.
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (w_is_msip && (XLEN'(h) == w_msip_lo) && w_mask[0])
          r_msip[h] <= i_membus_wdata[0];
        if (w_is_msip && (XLEN'(h) == w_msip_lo + 1'b1) && w_mask[32])
          r_msip[h] <= i_membus_wdata[32];
        if (w_is_cmp && (XLEN'(h) == w_cmp_idx))
          r_mtimecmp[h] <= (i_membus_wdata & w_mask) | (r_mtimecmp[h] & ~w_mask);
      end
    end
  end

  // A bus write to mtime overrides a coincident tick; the prescaler keeps running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div   <= '0;
      r_mtime <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_wr && w_is_mtime)
        r_mtime <= (i_membus_wdata & w_mask) | (r_mtime & ~w_mask);
      else if (w_tick)
        r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= i_membus_valid;
      if (w_rd) r_rdata <= w_rd_data;
    end
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_mtip
    assign o_mtip[h] = r_mtime >= r_mtimecmp[h];
  end

  assign o_membus_ready  = 1'b1;
  assign o_membus_rvalid = r_rvalid;
  assign o_membus_rdata  = r_rdata;
  assign o_msip          = r_msip;
  assign o_mtime         = r_mtime;

endmodule

// File: tb/tb_aclint_multi.sv
// Bench for aclint_multi: two instances (MTIME_DIV 1 and 4) checked against a
// register-map model through a response scoreboard plus directed spot checks.
module tb_aclint_multi;

  localparam logic [63:0] BASE  = 64'h0200_0000;
  localparam int          DIV_A = 1;
  localparam int          DIV_B = 4;

  typedef struct packed {
    logic        is_rd;
    logic [63:0] data;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        valid  [2];
  logic        ready  [2];
  logic [63:0] addr   [2];
  logic        wen    [2];
  logic [63:0] wdata  [2];
  logic [7:0]  wmask  [2];
  logic        rvalid [2];
  logic [63:0] rdata  [2];
  logic [1:0]  msip   [2];
  logic [1:0]  mtip   [2];
  logic [63:0] mtime  [2];

  logic [63:0] m_mtime [2];
  logic [63:0] m_cmp   [2][2];
  logic [1:0]  m_msip  [2];
  logic [63:0] m_rdata [2];
  int          m_div   [2];
  rsp_t        sb_q    [2][$];

  int n_checks = 0;
  int n_errors = 0;

  aclint_multi #(.NUM_HARTS(2), .XLEN(64), .BASE_ADDR(BASE), .MTIME_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(rst),
    .i_membus_valid(valid[0]), .o_membus_ready(ready[0]), .i_membus_addr(addr[0]),
    .i_membus_wen(wen[0]), .i_membus_wdata(wdata[0]), .i_membus_wmask(wmask[0]),
    .o_membus_rvalid(rvalid[0]), .o_membus_rdata(rdata[0]),
    .o_msip(msip[0]), .o_mtip(mtip[0]), .o_mtime(mtime[0])
  );

  aclint_multi #(.NUM_HARTS(2), .XLEN(64), .BASE_ADDR(BASE), .MTIME_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(rst),
    .i_membus_valid(valid[1]), .o_membus_ready(ready[1]), .i_membus_addr(addr[1]),
    .i_membus_wen(wen[1]), .i_membus_wdata(wdata[1]), .i_membus_wmask(wmask[1]),
    .o_membus_rvalid(rvalid[1]), .o_membus_rdata(rdata[1]),
    .o_msip(msip[1]), .o_mtip(mtip[1]), .o_mtime(mtime[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] res;
    res = old;
    for (int i = 0; i < 8; i++) if (m[i]) res[8*i +: 8] = d[8*i +: 8];
    return res;
  endfunction

  function automatic logic [63:0] model_read(input int g, input logic [63:0] off);
    case (off)
      64'h0000: return {31'b0, m_msip[g][1], 31'b0, m_msip[g][0]};
      64'h4000: return m_cmp[g][0];
      64'h4008: return m_cmp[g][1];
      64'hBFF8: return m_mtime[g];
      default:  return 64'h0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int D = (g == 0) ? DIV_A : DIV_B;
    logic [63:0] off;
    logic        wr;
    assign off = (addr[g] - BASE) & ~64'h7;
    assign wr  = valid[g] & wen[g];

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        m_mtime[g]  <= '0;
        m_div[g]    <= 0;
        m_msip[g]   <= '0;
        m_rdata[g]  <= '0;
        m_cmp[g][0] <= '1;
        m_cmp[g][1] <= '1;
        sb_q[g].delete();
      end else begin
        if (valid[g]) begin
          if (wen[g]) begin
            sb_q[g].push_back('{is_rd: 1'b0, data: m_rdata[g]});
          end else begin
            sb_q[g].push_back('{is_rd: 1'b1, data: model_read(g, off)});
            m_rdata[g] <= model_read(g, off);
          end
        end
        if (wr && off == 64'h0000) begin
          if (wmask[g][0]) m_msip[g][0] <= wdata[g][0];
          if (wmask[g][4]) m_msip[g][1] <= wdata[g][32];
        end
        if (wr && off == 64'h4000) m_cmp[g][0] <= merge(m_cmp[g][0], wdata[g], wmask[g]);
        if (wr && off == 64'h4008) m_cmp[g][1] <= merge(m_cmp[g][1], wdata[g], wmask[g]);
        m_div[g] <= (m_div[g] == D - 1) ? 0 : m_div[g] + 1;
        if (wr && off == 64'hBFF8)
          m_mtime[g] <= merge(m_mtime[g], wdata[g], wmask[g]);
        else if (m_div[g] == D - 1)
          m_mtime[g] <= m_mtime[g] + 64'd1;
      end
    end

    always @(negedge clk) begin
      if (rst === 1'b1) begin
        check($sformatf("mtime%0d", g), mtime[g], m_mtime[g]);
        check($sformatf("msip%0d", g), 64'(msip[g]), 64'(m_msip[g]));
        check($sformatf("mtip%0d", g), 64'(mtip[g]),
              64'({m_mtime[g] >= m_cmp[g][1], m_mtime[g] >= m_cmp[g][0]}));
        check($sformatf("ready%0d", g), 64'(ready[g]), 64'd1);
        if (sb_q[g].size() > 0) begin
          check($sformatf("rvalid%0d", g), 64'(rvalid[g]), 64'd1);
          check($sformatf("%s%0d", sb_q[g][0].is_rd ? "rdata" : "rdata_hold", g),
                rdata[g], sb_q[g][0].data);
          void'(sb_q[g].pop_front());
        end else begin
          check($sformatf("rvalid_idle%0d", g), 64'(rvalid[g]), 64'd0);
        end
      end
    end
  end

  // One request, accepted at the next posedge; returns 1 time unit after that edge.
  task automatic bus(input int g, input logic w, input logic [63:0] off,
                     input logic [63:0] d, input logic [7:0] m, input bit now = 1'b0);
    if (!now) @(negedge clk);
    valid[g] = 1'b1;
    wen[g]   = w;
    addr[g]  = BASE + off;
    wdata[g] = d;
    wmask[g] = m;
    @(posedge clk);
    #1;
    valid[g] = 1'b0;
    wen[g]   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    for (int g = 0; g < 2; g++) begin
      valid[g] = 1'b0; wen[g] = 1'b0; addr[g] = BASE; wdata[g] = '0; wmask[g] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_msip", 64'({msip[1], msip[0]}), 64'h0);
    check("rst_mtip", 64'({mtip[1], mtip[0]}), 64'h0);
    bus(0, 1'b0, 64'h4000, '0, '0);
    check("rst_cmp0_a", rdata[0], 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1, 1'b0, 64'h4008, '0, '0);
    check("rst_cmp1_b", rdata[1], 64'hFFFF_FFFF_FFFF_FFFF);
    bus(0, 1'b0, 64'hBFF8, '0, '0);
    bus(1, 1'b0, 64'hBFF8, '0, '0);

    // MSIP: hart 1 via upper lane, then a write whose lane is disabled
    bus(0, 1'b1, 64'h0000, 64'h1_0000_0000, 8'hF0);
    check("msip_set_hi", 64'(msip[0]), 64'h2);
    check("msip_wr_rvalid", 64'(rvalid[0]), 64'h1);
    bus(0, 1'b0, 64'h0000, '0, '0);
    check("msip_readback", rdata[0], 64'h1_0000_0000);
    bus(0, 1'b1, 64'h0000, 64'hFFFF_FFFF_0000_0001, 8'hF0);
    check("msip_lane_off", 64'(msip[0]), 64'h2);
    bus(1, 1'b1, 64'h0000, 64'h1, 8'h01);
    check("msip_set_lo_b", 64'(msip[1]), 64'h1);

    // mtime / mtimecmp with MTIME_DIV=1
    bus(0, 1'b1, 64'hBFF8, 64'd100, 8'hFF);
    bus(0, 1'b1, 64'h4000, 64'd105, 8'hFF);
    for (int i = 0; i < 50 && mtip[0][0] !== 1'b1; i++) begin
      bus(0, 1'b0, 64'hBFF8, '0, '0);
    end
    check("mtip0_rise", 64'(mtip[0][0]), 64'h1);
    check("mtime_at_rise", mtime[0], 64'd105);
    check("mtip1_low", 64'(mtip[0][1]), 64'h0);
    bus(0, 1'b1, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    check("mtip0_clear", 64'(mtip[0][0]), 64'h0);

    // Partial write of mtimecmp[1]
    bus(0, 1'b1, 64'h4008, 64'h1122_3344_5566_7788, 8'hFF);
    bus(0, 1'b1, 64'h4008, 64'h0000_0000_0000_00AA, 8'h01);
    bus(0, 1'b0, 64'h4008, '0, '0);
    check("cmp1_partial", rdata[0], 64'h1122_3344_5566_77AA);

    // Out-of-range hart and unmapped offset
    bus(0, 1'b1, 64'h4010, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    bus(0, 1'b0, 64'h4010, '0, '0);
    check("oor_read", rdata[0], 64'h0);
    bus(0, 1'b0, 64'h4008, '0, '0);
    check("oor_no_alias", rdata[0], 64'h1122_3344_5566_77AA);
    bus(0, 1'b0, 64'h8000, '0, '0);
    check("unmapped_read", rdata[0], 64'h0);

    // mtime wrap
    bus(0, 1'b1, 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    check("wrap_pre_mtip", 64'(mtip[0]), 64'h3);
    @(posedge clk);
    #1;
    check("wrap_mtime", mtime[0], 64'h0);
    check("wrap_mtip", 64'(mtip[0]), 64'h0);

    // MTIME_DIV=4: mtime write coinciding with a tick
    for (int i = 0; i < 8 && m_div[1] != DIV_B - 1; i++) @(negedge clk);
    check("tick_aligned", 64'(m_div[1]), 64'(DIV_B - 1));
    bus(1, 1'b1, 64'hBFF8, 64'h10, 8'hFF, 1'b1);
    bus(1, 1'b0, 64'hBFF8, '0, '0);
    check("tick_write_wins", rdata[1], 64'h10);
    repeat (9) @(negedge clk);
    bus(1, 1'b0, 64'hBFF8, '0, '0);
    bus(1, 1'b1, 64'h4000, 64'h12, 8'hFF);
    repeat (12) @(negedge clk);

    // Reset during an outstanding request
    @(negedge clk);
    valid[0] = 1'b1; wen[0] = 1'b0; addr[0] = BASE + 64'hBFF8;
    @(posedge clk);
    #2;
    valid[0] = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("rst_mid_rvalid", 64'(rvalid[0]), 64'h0);
    check("rst_mid_rdata", rdata[0], 64'h0);
    rst = 1'b1;
    bus(0, 1'b0, 64'h4000, '0, '0);
    check("post_rst_cmp0", rdata[0], 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(negedge clk);

    check("sb_drained", 64'(sb_q[0].size() + sb_q[1].size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
